// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, combinational ROM addressing and the IF/ID
// pipeline register with stall, flush, branch redirect and a small boot FSM.
module instr_fetch #(
  parameter int          ROM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  localparam int         AW        = $clog2(ROM_DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          STALL,
  input  logic          FLUSH,
  input  logic          BRANCH_TAKEN,
  input  logic [31:0]   BRANCH_TARGET,
  output logic [AW-1:0] ROM_ADDR,
  input  logic [31:0]   ROM_DATA,
  output logic [31:0]   PC_IF,
  output logic [31:0]   INSTR_ID,
  output logic [31:0]   PC_ID,
  output logic [31:0]   PC4_ID,
  output logic          VALID_ID,
  output logic          MISALIGN_ERR,
  output logic [31:0]   FETCH_CNT
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Boot leaves only on the first unstalled edge; the IF/ID load on that edge
  // is the ordinary fetch of the PC, which still holds RESET_PC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (!STALL) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (BRANCH_TAKEN)  pc_d = {BRANCH_TARGET[31:2], 2'b00};
    else if (!STALL)   pc_d = pc_plus4;
  end

  assign err_d = err_q | (BRANCH_TAKEN & (BRANCH_TARGET[1:0] != 2'b00));

  always_comb begin
    instr_d  = instr_q;
    pc_id_d  = pc_id_q;
    pc4_id_d = pc4_id_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (FLUSH) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!STALL) begin
      instr_d  = ROM_DATA;
      pc_id_d  = pc_q;
      pc4_id_d = pc_plus4;
      valid_d  = 1'b1;
      if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_id_q  <= 32'd0;
      pc4_id_q <= 32'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      pc4_id_q <= pc4_id_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ROM_ADDR     = pc_q[AW+1:2];
  assign PC_IF        = pc_q;
  assign INSTR_ID     = instr_q;
  assign PC_ID        = pc_id_q;
  assign PC4_ID       = pc4_id_q;
  assign VALID_ID     = valid_q;
  assign MISALIGN_ERR = err_q;
  assign FETCH_CNT    = cnt_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 1024, instruction ROM depth in 32-bit words; AW = $clog2(ROM_DEPTH).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013, bubble encoding (addi x0,x0,0).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 STALL  input  1  hold PC and IF/ID register.
REQ-007 FLUSH  input  1  load bubble into IF/ID.
REQ-008 BRANCH_TAKEN  input  1  redirect PC to BRANCH_TARGET.
REQ-009 BRANCH_TARGET  input  32  redirect byte address.
REQ-010 ROM_ADDR  output  AW  word address to the combinational instruction ROM.
REQ-011 ROM_DATA  input  32  instruction returned by the ROM in the same cycle.
REQ-012 PC_IF  output  32  current PC register value.
REQ-013 INSTR_ID  output  32  registered instruction to decode.
REQ-014 PC_ID  output  32  registered PC of INSTR_ID.
REQ-015 PC4_ID  output  32  registered PC_ID + 4.
REQ-016 VALID_ID  output  1  INSTR_ID is a real instruction, not a bubble.
REQ-017 MISALIGN_ERR  output  1  sticky flag: misaligned branch target seen.
REQ-018 FETCH_CNT  output  32  count of valid instructions delivered to IF/ID.

Function
REQ-019 ROM_ADDR SHALL equal PC[AW+1:2], combinational from the PC register; upper PC bits ignored (aliasing beyond ROM_DEPTH is permitted, no error).
REQ-020 Next PC priority per edge SHALL be: BRANCH_TAKEN -> {BRANCH_TARGET[31:2],2'b00}; else STALL -> hold; else PC+4 (32-bit modulo, 0xFFFF_FFFC wraps to 0).
REQ-021 BRANCH_TAKEN SHALL override STALL for the PC.
REQ-022 MISALIGN_ERR SHALL set on any edge with BRANCH_TAKEN=1 and BRANCH_TARGET[1:0]!=0, and remain set until RESET.
REQ-023 IF/ID priority per edge SHALL be: FLUSH -> INSTR_ID=NOP_INSTR, VALID_ID=0, PC_ID/PC4_ID unchanged; else STALL -> hold all; else INSTR_ID=ROM_DATA, PC_ID=PC, PC4_ID=PC+4, VALID_ID=1.
REQ-024 FLUSH SHALL override STALL for IF/ID; BRANCH_TAKEN alone SHALL NOT alter IF/ID (hazard logic asserts FLUSH).
REQ-025 Fetch latency SHALL be one cycle: instruction at PC appears on INSTR_ID after the next rising edge.
REQ-026 FETCH_CNT SHALL increment on each edge that loads IF/ID with VALID_ID=1 (REQ-023 third case), saturating at 32'hFFFF_FFFF.
REQ-027 Implementation SHALL contain a two-state control FSM: BOOT (first cycle after reset release, IF/ID load forced as bubble-free fetch of RESET_PC) and RUN; BOOT->RUN unconditionally on first edge without STALL.
REQ-028 In BOOT with STALL=1 the FSM SHALL remain in BOOT with VALID_ID=0.

Reset
REQ-029 RESET=1 SHALL immediately force: PC=RESET_PC, INSTR_ID=NOP_INSTR, PC_ID=0, PC4_ID=0, VALID_ID=0, MISALIGN_ERR=0, FETCH_CNT=0, FSM=BOOT.
REQ-030 Reset asserted mid-stall, mid-branch or mid-flush SHALL discard that operation; no input is sampled while RESET=1.
REQ-031 After reset release, first rising edge without STALL SHALL load ROM[RESET_PC>>2] into INSTR_ID with VALID_ID=1.

Verification
REQ-032 Sequential run: ROM[0..3]=A0..A3, no stall -> INSTR_ID A0,A1,A2,A3 on edges 1-4, PC_ID 0,4,8,C, FETCH_CNT=4.
REQ-033 Stall: STALL=1 for 2 cycles at PC=8 -> PC_IF stays 8, INSTR_ID holds A1, FETCH_CNT unchanged, then A2 resumes.
REQ-034 Branch+flush: BRANCH_TAKEN=1, FLUSH=1, TARGET=0x40, STALL=1 -> PC_IF=0x40, VALID_ID=0, INSTR_ID=0x00000013; next edge INSTR_ID=ROM[16].
REQ-035 Misaligned: TARGET=0x43 -> PC_IF=0x40, MISALIGN_ERR=1, stays 1 through later branches until RESET.
REQ-036 Wrap/alias: PC=0x0000_0FFC with ROM_DEPTH=1024 -> ROM_ADDR=1023, next PC=0x1000, ROM_ADDR=0; PC=0xFFFF_FFFC -> next PC=0.
REQ-037 Async reset mid-run: RESET pulse between edges -> outputs at reset values before next edge; first post-reset edge delivers ROM[RESET_PC>>2].
